// File: rtl/id_branch_resolve_pkg.sv
// Shared pipeline definitions for the ID-stage branch logic: forwarding-select
// encodings (also used by the forwarding-select unit) and the stall FSM states.
package id_branch_resolve_pkg;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   localparam logic [1:0] FWD_WB  = 2'd3;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } br_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/id_branch_resolve_if.sv
// ID-stage branch bundle: decoded branch, operand sources, hazard info in;
// stall/redirect/flush and statistics out.
interface id_branch_resolve_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
);
   logic              id_valid;
   logic              id_is_beq;
   logic              id_is_bne;
   logic [DATA_W-1:0] id_pc_plus4;
   logic [DATA_W-1:0] id_imm;
   logic [DATA_W-1:0] rf_rs_data;
   logic [DATA_W-1:0] rf_rt_data;
   logic [DATA_W-1:0] ex_result;
   logic [DATA_W-1:0] mem_result;
   logic [DATA_W-1:0] wb_result;
   logic [1:0]        beq_src1;
   logic [1:0]        beq_src2;
   logic              ex_is_load;
   logic              mem_is_load;
   logic              stall_id;
   logic              pc_redirect;
   logic [DATA_W-1:0] branch_target;
   logic              flush_if_id;
   logic [CNT_W-1:0]  branch_cnt;
   logic [CNT_W-1:0]  taken_cnt;

   modport master (
      output id_valid, id_is_beq, id_is_bne, id_pc_plus4, id_imm,
             rf_rs_data, rf_rt_data, ex_result, mem_result, wb_result,
             beq_src1, beq_src2, ex_is_load, mem_is_load,
      input  stall_id, pc_redirect, branch_target, flush_if_id,
             branch_cnt, taken_cnt
   );

   modport slave (
      input  id_valid, id_is_beq, id_is_bne, id_pc_plus4, id_imm,
             rf_rs_data, rf_rt_data, ex_result, mem_result, wb_result,
             beq_src1, beq_src2, ex_is_load, mem_is_load,
      output stall_id, pc_redirect, branch_target, flush_if_id,
             branch_cnt, taken_cnt
   );

endinterface

// File: rtl/br_operand_mux.sv
// 4:1 operand mux selecting register-file or forwarded data for a branch
// comparison operand.
module br_operand_mux
   import id_branch_resolve_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        sel,
   input  logic [DATA_W-1:0] rf_data,
   input  logic [DATA_W-1:0] ex_data,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = rf_data;
      case (sel)
         FWD_RF:  y = rf_data;
         FWD_EX:  y = ex_data;
         FWD_MEM: y = mem_data;
         FWD_WB:  y = wb_data;
         default: y = rf_data;
      endcase
   end

endmodule

// File: rtl/id_branch_resolve.sv
// ID-stage branch resolution: operand forwarding mux, beq/bne compare, PC
// redirect and IF/ID flush, load-use stall FSM and branch statistics.
module id_branch_resolve
   import id_branch_resolve_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int CNT_W          = 32,
   parameter int EX_LOAD_STALL  = 2,
   parameter int MEM_LOAD_STALL = 1
) (
   input logic                clk,
   input logic                rst_n,
   id_branch_resolve_if.slave br
);

   localparam int STALL_MAX = max_int(EX_LOAD_STALL, MEM_LOAD_STALL);
   localparam int SCNT_W    = $clog2(STALL_MAX) + 1;
   // Reload values count the remaining STALL cycles after the detecting cycle.
   localparam logic [SCNT_W-1:0] EX_RELOAD  = SCNT_W'(EX_LOAD_STALL - 1);
   localparam logic [SCNT_W-1:0] MEM_RELOAD = SCNT_W'(MEM_LOAD_STALL - 1);

   br_state_e          state_q, state_d;
   logic [SCNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;

   logic [DATA_W-1:0]  op1, op2;
   logic               is_br, haz_ex, haz_mem;
   logic               eq, taken, resolve, stall_id;

   br_operand_mux #(.DATA_W(DATA_W)) u_mux_rs (
      .sel      (br.beq_src1),
      .rf_data  (br.rf_rs_data),
      .ex_data  (br.ex_result),
      .mem_data (br.mem_result),
      .wb_data  (br.wb_result),
      .y        (op1)
   );

   br_operand_mux #(.DATA_W(DATA_W)) u_mux_rt (
      .sel      (br.beq_src2),
      .rf_data  (br.rf_rt_data),
      .ex_data  (br.ex_result),
      .mem_data (br.mem_result),
      .wb_data  (br.wb_result),
      .y        (op2)
   );

   assign is_br   = br.id_valid & (br.id_is_beq | br.id_is_bne);
   assign haz_ex  = br.ex_is_load  & ((br.beq_src1 == FWD_EX)  | (br.beq_src2 == FWD_EX));
   assign haz_mem = br.mem_is_load & ((br.beq_src1 == FWD_MEM) | (br.beq_src2 == FWD_MEM));
   assign eq      = (op1 == op2);
   // beq wins when decode asserts both flags.
   assign taken   = br.id_is_beq ? eq : (br.id_is_bne & ~eq);

   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      stall_id    = 1'b0;
      resolve     = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_br) begin
               if (haz_ex) begin
                  stall_id    = 1'b1;
                  stall_cnt_d = EX_RELOAD;
                  if (EX_RELOAD != '0) state_d = STALL;
               end else if (haz_mem) begin
                  stall_id    = 1'b1;
                  stall_cnt_d = MEM_RELOAD;
                  if (MEM_RELOAD != '0) state_d = STALL;
               end else begin
                  resolve = 1'b1;
               end
            end
         end
         STALL: begin
            stall_id    = 1'b1;
            stall_cnt_d = stall_cnt_q - 1'b1;
            if (stall_cnt_q == SCNT_W'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      branch_cnt_d = branch_cnt_q;
      taken_cnt_d  = taken_cnt_q;
      if (resolve) begin
         branch_cnt_d = branch_cnt_q + 1'b1;
         if (taken) taken_cnt_d = taken_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         stall_cnt_q  <= '0;
         branch_cnt_q <= '0;
         taken_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         stall_cnt_q  <= stall_cnt_d;
         branch_cnt_q <= branch_cnt_d;
         taken_cnt_q  <= taken_cnt_d;
      end
   end

   assign br.stall_id      = stall_id;
   assign br.pc_redirect   = resolve & taken;
   assign br.flush_if_id   = resolve & taken;
   assign br.branch_target = br.id_pc_plus4 + (br.id_imm << 2);
   assign br.branch_cnt    = branch_cnt_q;
   assign br.taken_cnt     = taken_cnt_q;

endmodule

// File: tb/tb_id_branch_resolve.sv
// Scoreboard bench for id_branch_resolve (CNT_W=4 build so counter wrap is reachable).
module tb_id_branch_resolve;
   import id_branch_resolve_pkg::*;

   localparam int DW = 32;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   id_branch_resolve_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

   id_branch_resolve #(
      .DATA_W(DW), .CNT_W(CW), .EX_LOAD_STALL(2), .MEM_LOAD_STALL(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .br    (bus)
   );

   typedef struct {
      logic          stall;
      logic          redir;
      logic [DW-1:0] tgt;
      logic [CW-1:0] bcnt;
      logic [CW-1:0] tcnt;
   } exp_t;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_err = 0;
   logic [CW-1:0] m_b = '0;
   logic [CW-1:0] m_t = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic set_br(input logic v, input logic beq, input logic bne,
                         input logic [1:0] s1, input logic [1:0] s2,
                         input logic exl, input logic meml);
      bus.id_valid    = v;
      bus.id_is_beq   = beq;
      bus.id_is_bne   = bne;
      bus.beq_src1    = s1;
      bus.beq_src2    = s2;
      bus.ex_is_load  = exl;
      bus.mem_is_load = meml;
   endtask

   // Called at posedge+1 with inputs already applied; ends at the next posedge+1.
   task automatic step(input string tag, input logic e_stall, input logic e_redir);
      exp_t e, o;
      logic res;
      res = bus.id_valid & (bus.id_is_beq | bus.id_is_bne) & ~e_stall;
      if (res) m_b = m_b + 1'b1;
      if (res & e_redir) m_t = m_t + 1'b1;
      e.stall = e_stall;
      e.redir = e_redir;
      e.tgt   = bus.id_pc_plus4 + {bus.id_imm[DW-3:0], 2'b00};
      e.bcnt  = m_b;
      e.tcnt  = m_t;
      sb.push_back(e);
      @(negedge clk);
      o = sb.pop_front();
      chk({tag, ".stall"}, 32'(bus.stall_id), 32'(o.stall));
      chk({tag, ".redir"}, 32'(bus.pc_redirect), 32'(o.redir));
      chk({tag, ".flush"}, 32'(bus.flush_if_id), 32'(o.redir));
      chk({tag, ".tgt"}, bus.branch_target, o.tgt);
      @(posedge clk);
      #1;
      chk({tag, ".bcnt"}, 32'(bus.branch_cnt), 32'(o.bcnt));
      chk({tag, ".tcnt"}, 32'(bus.taken_cnt), 32'(o.tcnt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      set_br(1'b0, 1'b0, 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
      bus.id_pc_plus4 = 32'h100;
      bus.id_imm      = 32'hFFFF_FFFE;
      bus.rf_rs_data  = '0;
      bus.rf_rt_data  = '0;
      bus.ex_result   = '0;
      bus.mem_result  = '0;
      bus.wb_result   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.stall", 32'(bus.stall_id), 0);
      chk("rst.redir", 32'(bus.pc_redirect), 0);
      chk("rst.flush", 32'(bus.flush_if_id), 0);
      chk("rst.bcnt", 32'(bus.branch_cnt), 0);
      chk("rst.tcnt", 32'(bus.taken_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // beq from register file, equal operands, backward target
      bus.rf_rs_data = 32'h5; bus.rf_rt_data = 32'h5;
      set_br(1'b1, 1'b1, 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
      step("beq_rf", 1'b0, 1'b1);

      // bne with rs forwarded from a non-load EX result, equal -> not taken
      bus.ex_result = 32'h7; bus.rf_rt_data = 32'h7;
      set_br(1'b1, 1'b0, 1'b1, FWD_EX, FWD_RF, 1'b0, 1'b0);
      step("bne_ex", 1'b0, 1'b0);

      // rs from a load in EX: two stall cycles, then resolve from WB
      bus.rf_rt_data = 32'h33; bus.ex_result = 32'h99;
      set_br(1'b1, 1'b1, 1'b0, FWD_EX, FWD_RF, 1'b1, 1'b0);
      step("exld_s0", 1'b1, 1'b0);
      step("exld_s1", 1'b1, 1'b0);
      bus.wb_result = 32'h33;
      set_br(1'b1, 1'b1, 1'b0, FWD_WB, FWD_RF, 1'b1, 1'b0);
      step("exld_res", 1'b0, 1'b1);

      // rt from a load in MEM: one stall cycle
      bus.rf_rs_data = 32'h44; bus.mem_result = 32'h1;
      set_br(1'b1, 1'b1, 1'b0, FWD_RF, FWD_MEM, 1'b0, 1'b1);
      step("memld_s0", 1'b1, 1'b0);
      bus.wb_result = 32'h44;
      set_br(1'b1, 1'b1, 1'b0, FWD_RF, FWD_WB, 1'b0, 1'b1);
      step("memld_res", 1'b0, 1'b1);

      // both hazards: EX priority gives the longer stall
      set_br(1'b1, 1'b1, 1'b0, FWD_EX, FWD_MEM, 1'b1, 1'b1);
      step("prio_s0", 1'b1, 1'b0);
      step("prio_s1", 1'b1, 1'b0);
      bus.id_imm = 32'h0000_0010;
      set_br(1'b1, 1'b1, 1'b0, FWD_WB, FWD_WB, 1'b0, 1'b0);
      step("prio_res", 1'b0, 1'b1);

      // beq and bne both set behave as beq
      bus.rf_rs_data = 32'hA; bus.rf_rt_data = 32'hA;
      set_br(1'b1, 1'b1, 1'b1, FWD_RF, FWD_RF, 1'b0, 1'b0);
      step("both_eq", 1'b0, 1'b1);
      bus.rf_rt_data = 32'hB;
      step("both_ne", 1'b0, 1'b0);
      set_br(1'b1, 1'b0, 1'b1, FWD_RF, FWD_RF, 1'b0, 1'b0);
      step("bne_ne", 1'b0, 1'b1);

      // invalid slot and non-branch instruction never stall, redirect or count
      set_br(1'b0, 1'b1, 1'b0, FWD_EX, FWD_RF, 1'b1, 1'b0);
      step("inval", 1'b0, 1'b0);
      set_br(1'b1, 1'b0, 1'b0, FWD_EX, FWD_MEM, 1'b1, 1'b1);
      step("nonbr", 1'b0, 1'b0);

      // id_valid dropping mid-stall does not abort the stall
      set_br(1'b1, 1'b1, 1'b0, FWD_EX, FWD_RF, 1'b1, 1'b0);
      step("drop_s0", 1'b1, 1'b0);
      bus.id_valid = 1'b0;
      step("drop_s1", 1'b1, 1'b0);
      step("drop_idle", 1'b0, 1'b0);

      // async reset during the second EX-load stall cycle
      set_br(1'b1, 1'b1, 1'b0, FWD_EX, FWD_RF, 1'b1, 1'b0);
      bus.rf_rs_data = 32'h21; bus.rf_rt_data = 32'h55; bus.wb_result = 32'h55;
      step("rs_s0", 1'b1, 1'b0);
      @(negedge clk);
      chk("rs_s1.stall", 32'(bus.stall_id), 1);
      rst_n = 1'b0;
      bus.id_valid = 1'b0;
      #1;
      m_b = '0; m_t = '0;
      chk("rs_in.stall", 32'(bus.stall_id), 0);
      chk("rs_in.redir", 32'(bus.pc_redirect), 0);
      chk("rs_in.bcnt", 32'(bus.branch_cnt), 32'(m_b));
      chk("rs_in.tcnt", 32'(bus.taken_cnt), 32'(m_t));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.id_valid = 1'b1;
      step("rs_re_s0", 1'b1, 1'b0);
      step("rs_re_s1", 1'b1, 1'b0);
      set_br(1'b1, 1'b1, 1'b0, FWD_WB, FWD_RF, 1'b0, 1'b0);
      step("rs_re_res", 1'b0, 1'b1);

      // counter wrap: bring branch_cnt to 15, then one more resolve
      bus.rf_rs_data = 32'h3; bus.rf_rt_data = 32'h3;
      for (int i = 0; m_b != 4'd15 && i < 20; i++) begin
         bus.id_is_beq = i[0];
         bus.id_is_bne = ~i[0];
         set_br(1'b1, i[0], ~i[0], FWD_RF, FWD_RF, 1'b0, 1'b0);
         step("fill", 1'b0, i[0]);
      end
      chk("pre_wrap.bcnt", 32'(bus.branch_cnt), 15);
      for (int i = 0; i < 3; i++) begin
         set_br(1'b1, 1'b0, 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
         step("nb_hold", 1'b0, 1'b0);
      end
      set_br(1'b1, 1'b1, 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
      step("wrap", 1'b0, 1'b1);
      chk("wrap.bcnt0", 32'(bus.branch_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/id_branch_resolve.md
Name: id_branch_resolve

Overview:
ID-stage branch resolution unit, directly downstream of the branch forwarding-select unit. Consumes the 2-bit per-operand forwarding selects (0=RF, 1=EX, 2=MEM, 3=WB) and muxes the operand data. Compares the operands for beq/bne, and drives PC redirect plus the IF/ID flush. Owns the load-use stall FSM for branches: an operand forwarded from a load still in EX or MEM cannot be compared yet, so the FSM stalls. Keeps branch and taken statistics counters.

Parameters:
DATA_W, 32, operand/PC width
CNT_W, 32, statistics counter width
EX_LOAD_STALL, 2, stall cycles when a needed operand comes from a load in EX
MEM_LOAD_STALL, 1, stall cycles when a needed operand comes from a load in MEM

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_is_beq  in  1  ID instruction is beq
id_is_bne  in  1  ID instruction is bne
id_pc_plus4  in  DATA_W  PC+4 of ID instruction
id_imm  in  DATA_W  sign-extended 16-bit offset
rf_rs_data  in  DATA_W  register-file rs read
rf_rt_data  in  DATA_W  register-file rt read
ex_result  in  DATA_W  EX-stage ALU result
mem_result  in  DATA_W  MEM-stage result
wb_result  in  DATA_W  WB write data
beq_src1  in  2  rs forwarding select
beq_src2  in  2  rt forwarding select
ex_is_load  in  1  EX instruction is a load
mem_is_load  in  1  MEM instruction is a load
stall_id  out  1  freeze PC and IF/ID; insert bubble into ID/EX
pc_redirect  out  1  load PC with branch_target
branch_target  out  DATA_W  id_pc_plus4 + (id_imm << 2), mod 2^DATA_W
flush_if_id  out  1  kill the instruction in IF/ID
branch_cnt  out  CNT_W  resolved branches
taken_cnt  out  CNT_W  taken branches

Behaviour:
- is_br = id_valid & (id_is_beq | id_is_bne). Operand mux: select 0/1/2/3 chooses rf/ex/mem/wb data.
- Hazard, evaluated only in IDLE with is_br:
  - haz_ex = ex_is_load & (beq_src1==1 | beq_src2==1).
  - haz_mem = mem_is_load & (beq_src1==2 | beq_src2==2).
  - haz_ex takes priority over haz_mem.
- FSM states: IDLE, STALL. Down-counter stall_cnt, width clog2(max stall)+1.
  - IDLE, is_br & haz_ex: stall_id=1 this cycle; load stall_cnt=EX_LOAD_STALL-1; go to STALL if the loaded value is >0, else stay IDLE.
  - IDLE, is_br & haz_mem (no haz_ex): stall_id=1; load stall_cnt=MEM_LOAD_STALL-1; same rule.
  - STALL: stall_id=1; no hazard evaluation and no resolution; decrement stall_cnt; return to IDLE when stall_cnt==1. Total stall = exact parameter value.
  - IDLE, is_br, no hazard: resolve this cycle (combinational). For the same branch after its stall, the selects have advanced, so it resolves on re-evaluation.
- Resolve:
  - eq = (op1==op2).
  - taken = (id_is_beq & eq) | (id_is_bne & ~eq).
  - pc_redirect = flush_if_id = taken; stall_id=0.
- id_is_beq and id_is_bne both 1: treated as beq (beq priority).
- Outputs in all non-resolve cycles: pc_redirect=0, flush_if_id=0. branch_target is always driven combinationally.
- Counters:
  - At the rising edge of a resolve cycle: branch_cnt+=1; taken_cnt+=1 if taken.
  - Both counters wrap modulo 2^CNT_W.
  - A stalled branch counts once, at resolution only.
- Reset (async, any state, including mid-STALL): state=IDLE, stall_cnt=0, counters=0. Combinational outputs then evaluate from IDLE; with id_valid=0 they are stall_id=0, pc_redirect=0, flush_if_id=0.
- id_valid falling while in STALL does not abort; the stall runs to completion.

Decomposition:
- Shared pipeline package holds:
  - forwarding-select constants FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3, also used by the forwarding-select unit;
  - FSM state typedef {IDLE, STALL}.
- One natural sub-module: br_operand_mux (4:1 DATA_W mux), instantiated twice.

Test Plan:
- beq, selects 0/0, rf_rs=rf_rt=0x5 -> same cycle pc_redirect=1, flush_if_id=1, stall_id=0; pc_plus4=0x100, imm=0xFFFFFFFE -> branch_target=0xF8; branch_cnt=1, taken_cnt=1.
- bne, beq_src1=1, ex_result=0x7, rf_rt=0x7, ex_is_load=0 -> not taken, no stall; branch_cnt increments, taken_cnt does not.
- beq, beq_src1=1, ex_is_load=1 -> stall_id=1 for exactly 2 cycles. Then selects become 3, wb_result matches rt -> redirect in 3rd cycle; branch_cnt +1 only once.
- beq, beq_src2=2, mem_is_load=1 -> 1 stall cycle, then resolve using the wb select.
- rst_n low for 1 cycle during the 2nd EX-load stall cycle -> state IDLE, counters 0; after release the same branch re-detects the hazard if the inputs still show it.
- branch_cnt preloaded near wrap (CNT_W=4 build, 15 resolves then 1 more) -> wraps to 0; non-branch id_valid cycles never change the counters.
